// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer.
//   state_t    : controller states (IDLE, RUN)
//   BCD_MAX    : largest legal BCD nibble
//   bcd_clamp  : saturates a nibble to the legal BCD range
package bcd_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One registered BCD digit of a down-counter.
//   clk        : clock, rising edge
//   res        : synchronous active-high reset (digit -> 0)
//   load       : write load_val into the digit (wins over dec)
//   load_val   : value to write, already legal BCD
//   dec        : decrement enable for the whole chain
//   borrow_in  : borrow from the less significant digit
//   digit      : current digit value
//   borrow_out : borrow to the more significant digit
module bcd_digit_down
    import bcd_pkg::*;
(
    input  logic       clk,
    input  logic       res,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    // A digit only borrows onward when it is 0 and is itself being borrowed from.
    assign borrow_out = borrow_in && (digit == 4'd0);

    always_ff @(posedge clk) begin
        if (res) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec && borrow_in) begin
            digit <= (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with parallel load, start/enable control,
// single-cycle terminal-count pulse and optional auto-reload.
//   CLK      : clock, rising edge
//   RES      : synchronous active-high reset
//   LOAD     : parallel load strobe (any state, aborts a run)
//   LOAD_VAL : packed BCD load value, digit 0 in [3:0]; nibbles >9 clamp to 9
//   START    : begin countdown from IDLE
//   EN       : count enable while in RUN
//   COUNT    : current packed BCD value
//   BUSY     : high while in RUN
//   DONE     : one-cycle terminal-count pulse
//   ERR      : last load had an out-of-range nibble (sticky until next LOAD)
module bcd_countdown_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  LOAD,
    input  logic [4*DIGITS-1:0]   LOAD_VAL,
    input  logic                  START,
    input  logic                  EN,
    output logic [4*DIGITS-1:0]   COUNT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR
);

    localparam int W = 4 * DIGITS;

    state_t         state, state_nxt;
    logic           done_nxt;
    logic [W-1:0]   reload_reg;
    logic [W-1:0]   load_clamped;
    logic           clamped_any;
    logic           zero, one;
    logic           dec, term;
    logic           dig_load;
    logic [W-1:0]   dig_val;
    logic [DIGITS:0] borrow;

    always_comb begin
        load_clamped = '0;
        clamped_any  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = bcd_clamp(LOAD_VAL[4*i +: 4]);
            if (LOAD_VAL[4*i +: 4] > BCD_MAX) clamped_any = 1'b1;
        end
    end

    assign zero = (COUNT == '0);
    assign one  = (COUNT == W'(1));

    // LOAD outranks counting, so a decrement never coincides with a load.
    assign dec  = (state == RUN) && EN && !LOAD;
    // Terminal count: this edge would take COUNT from 1 to 0.
    assign term = dec && one;

    // On auto-reload the reload value overwrites what the decrement would give.
    assign dig_load = LOAD || (term && AUTO_RELOAD);
    assign dig_val  = LOAD ? load_clamped : reload_reg;

    assign borrow[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit_down u_dig (
            .clk        (CLK),
            .res        (RES),
            .load       (dig_load),
            .load_val   (dig_val[4*g +: 4]),
            .dec        (dec),
            .borrow_in  (borrow[g]),
            .digit      (COUNT[4*g +: 4]),
            .borrow_out (borrow[g+1])
        );
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RES) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and DONE decision
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (!LOAD) begin
            case (state)
                IDLE: begin
                    if (START) begin
                        if (zero) done_nxt  = 1'b1;
                        else      state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (term) begin
                        done_nxt = 1'b1;
                        // A zero reload value has nothing to count; stop instead.
                        if (!AUTO_RELOAD || (reload_reg == '0)) state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end else begin
            state_nxt = IDLE;
        end
    end

    // Outputs derived from registered state only
    always_comb begin
        BUSY = (state == RUN);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            reload_reg <= '0;
        end else begin
            DONE <= done_nxt;
            if (LOAD) begin
                ERR        <= clamped_any;
                reload_reg <= load_clamped;
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DIGITS=2, no auto-reload
    logic        res_a, load_a, start_a, en_a;
    logic [7:0]  lv_a, cnt_a;
    logic        busy_a, done_a, err_a;
    // DUT B: DIGITS=3, no auto-reload
    logic        res_b, load_b, start_b, en_b;
    logic [11:0] lv_b, cnt_b;
    logic        busy_b, done_b, err_b;
    // DUT C: DIGITS=2, auto-reload
    logic        res_c, load_c, start_c, en_c;
    logic [7:0]  lv_c, cnt_c;
    logic        busy_c, done_c, err_c;

    bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut_a (
        .CLK(clk), .RES(res_a), .LOAD(load_a), .LOAD_VAL(lv_a), .START(start_a), .EN(en_a),
        .COUNT(cnt_a), .BUSY(busy_a), .DONE(done_a), .ERR(err_a));
    bcd_countdown_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut_b (
        .CLK(clk), .RES(res_b), .LOAD(load_b), .LOAD_VAL(lv_b), .START(start_b), .EN(en_b),
        .COUNT(cnt_b), .BUSY(busy_b), .DONE(done_b), .ERR(err_b));
    bcd_countdown_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut_c (
        .CLK(clk), .RES(res_c), .LOAD(load_c), .LOAD_VAL(lv_c), .START(start_c), .EN(en_c),
        .COUNT(cnt_c), .BUSY(busy_c), .DONE(done_c), .ERR(err_c));

    typedef struct {
        int          sel;
        string       tag;
        logic [14:0] v;     // {count[11:0], busy, done, err}
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    function automatic logic [11:0] to_bcd(input int n);
        logic [11:0] r;
        r[11:8] = 4'((n / 100) % 10);
        r[7:4]  = 4'((n / 10) % 10);
        r[3:0]  = 4'(n % 10);
        return r;
    endfunction

    task automatic push(input int sel, input string tag, input logic [11:0] c,
                        input logic b, input logic d, input logic e);
        exp_t x;
        x.sel = sel;
        x.tag = tag;
        x.v   = {c, b, d, e};
        sb.push_back(x);
    endtask

    // Advance one edge, sample 1 time unit later, drain the scoreboard.
    task automatic tick();
        exp_t        x;
        logic [14:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            case (x.sel)
                0:       obs = {4'h0, cnt_a, busy_a, done_a, err_a};
                1:       obs = {cnt_b, busy_b, done_b, err_b};
                default: obs = {4'h0, cnt_c, busy_c, done_c, err_c};
            endcase
            total++;
            assert (obs === x.v) passed++;
            else $error("FAIL %s: got count=%h busy=%b done=%b err=%b, expected count=%h busy=%b done=%b err=%b",
                        x.tag, obs[14:3], obs[2], obs[1], obs[0], x.v[14:3], x.v[2], x.v[1], x.v[0]);
        end
    endtask

    initial begin
        res_a = 1; load_a = 0; start_a = 0; en_a = 0; lv_a = 8'h25;
        res_b = 1; load_b = 0; start_b = 0; en_b = 0; lv_b = '0;
        res_c = 1; load_c = 0; start_c = 0; en_c = 0; lv_c = '0;

        // Reset
        push(0, "reset_a", 12'h000, 0, 0, 0);
        push(1, "reset_b", 12'h000, 0, 0, 0);
        push(2, "reset_c", 12'h000, 0, 0, 0);
        tick();
        res_a = 0; res_b = 0; res_c = 0;

        // Load
        load_a = 1; lv_a = 8'h25;
        push(0, "load_25", 12'h025, 0, 0, 0); tick();

        // Full countdown from 12
        lv_a = 8'h12;
        push(0, "load_12", 12'h012, 0, 0, 0); tick();
        load_a = 0; start_a = 1; en_a = 1;
        push(0, "start_busy", 12'h012, 1, 0, 0); tick();
        start_a = 0;
        for (int k = 11; k >= 1; k--) begin
            push(0, $sformatf("down_%0d", k), to_bcd(k), 1, 0, 0); tick();
        end
        push(0, "term_done", 12'h000, 0, 1, 0); tick();
        push(0, "done_once", 12'h000, 0, 0, 0); tick();

        // Borrow chain and EN gating on 3 digits
        load_b = 1; lv_b = 12'h100;
        push(1, "load_100", 12'h100, 0, 0, 0); tick();
        load_b = 0; start_b = 1; en_b = 1;
        push(1, "start_100", 12'h100, 1, 0, 0); tick();
        start_b = 0;
        push(1, "borrow_099", 12'h099, 1, 0, 0); tick();
        en_b = 0;
        for (int k = 0; k < 3; k++) begin
            push(1, "en_hold", 12'h099, 1, 0, 0); tick();
        end
        en_b = 1;
        push(1, "resume_098", 12'h098, 1, 0, 0); tick();

        // Clamp, then abort a run with LOAD
        load_a = 1; lv_a = 8'hA7;
        push(0, "clamp_A7", 12'h097, 0, 0, 1); tick();
        load_a = 0; start_a = 1; en_a = 1;
        push(0, "start_97", 12'h097, 1, 0, 1); tick();
        start_a = 0;
        for (int k = 96; k >= 94; k--) begin
            push(0, $sformatf("err_sticky_%0d", k), to_bcd(k), 1, 0, 1); tick();
        end
        load_a = 1; lv_a = 8'h05;
        push(0, "abort_load", 12'h005, 0, 0, 0); tick();
        load_a = 0;
        push(0, "idle_ignores_en", 12'h005, 0, 0, 0); tick();

        // Zero start
        load_a = 1; lv_a = 8'h00;
        push(0, "load_0", 12'h000, 0, 0, 0); tick();
        load_a = 0; start_a = 1;
        push(0, "zero_start_done", 12'h000, 0, 1, 0); tick();
        start_a = 0;
        push(0, "zero_done_once", 12'h000, 0, 0, 0); tick();

        // LOAD and START together
        load_a = 1; start_a = 1; lv_a = 8'h34;
        push(0, "load_beats_start", 12'h034, 0, 0, 0); tick();
        load_a = 0; start_a = 0;
        push(0, "stay_idle", 12'h034, 0, 0, 0); tick();

        // LOAD on the terminal-count edge
        load_a = 1; lv_a = 8'h01;
        push(0, "load_01", 12'h001, 0, 0, 0); tick();
        load_a = 0; start_a = 1; en_a = 1;
        push(0, "start_01", 12'h001, 1, 0, 0); tick();
        start_a = 0; load_a = 1; lv_a = 8'h22;
        push(0, "load_beats_term", 12'h022, 0, 0, 0); tick();
        load_a = 0;

        // Reset in the middle of a run
        start_a = 1;
        push(0, "run_again", 12'h022, 1, 0, 0); tick();
        start_a = 0;
        push(0, "run_21", 12'h021, 1, 0, 0); tick();
        res_a = 1;
        push(0, "reset_in_run", 12'h000, 0, 0, 0); tick();
        res_a = 0; en_a = 0;

        // Auto-reload from 3
        load_c = 1; lv_c = 8'h03;
        push(2, "ar_load_03", 12'h003, 0, 0, 0); tick();
        load_c = 0; start_c = 1; en_c = 1;
        push(2, "ar_start", 12'h003, 1, 0, 0); tick();
        start_c = 0;
        for (int r = 0; r < 2; r++) begin
            push(2, "ar_02", 12'h002, 1, 0, 0); tick();
            push(2, "ar_01", 12'h001, 1, 0, 0); tick();
            push(2, "ar_reload", 12'h003, 1, 1, 0); tick();
        end
        push(2, "ar_after", 12'h002, 1, 0, 0); tick();

        // Auto-reload with value 1: DONE every cycle
        load_c = 1; lv_c = 8'h01;
        push(2, "ar_load_01", 12'h001, 0, 0, 0); tick();
        load_c = 0; start_c = 1;
        push(2, "ar_start_01", 12'h001, 1, 0, 0); tick();
        start_c = 0;
        push(2, "ar_done_1a", 12'h001, 1, 1, 0); tick();
        push(2, "ar_done_1b", 12'h001, 1, 1, 0); tick();

        // Auto-reload with value 0: zero start behaves like plain mode
        load_c = 1; lv_c = 8'h00;
        push(2, "ar_load_00", 12'h000, 0, 0, 0); tick();
        load_c = 0; start_c = 1;
        push(2, "ar_zero_start", 12'h000, 0, 1, 0); tick();
        start_c = 0;
        push(2, "ar_zero_idle", 12'h000, 0, 0, 0); tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Synchronous, multi-digit BCD down-counter with parallel load, start/enable control, terminal-count pulse, and optional auto-reload. It counts in the opposite direction to the team's ripple BCD up-counter. Its intended use is as the countdown half of timer and display paths that consume packed BCD digits. All state is updated on one clock edge; there are no ripple clocks.

## Interface
- DIGITS, 2: number of BCD digits (1..8); COUNT width is 4*DIGITS.
- AUTO_RELOAD, 0: when 1, reaching zero reloads the last loaded value and keeps running.
- CLK  input  1  clock; all state updates on the rising edge.
- RES  input  1  reset, synchronous, active-high.
- LOAD  input  1  parallel load strobe.
- LOAD_VAL  input  4*DIGITS  packed BCD load value; digit 0 is bits [3:0].
- START  input  1  begins a countdown from IDLE.
- EN  input  1  count enable; one decrement per cycle while high in RUN.
- COUNT  output  4*DIGITS  current packed BCD value.
- BUSY  output  1  high while in RUN.
- DONE  output  1  single-cycle terminal-count pulse.
- ERR  output  1  set when a load contained a digit >9; sticky until the next LOAD.

## Operation
- States: IDLE, RUN.
- Reset (RES=1 at the edge): COUNT=0, RELOAD_REG=0, state=IDLE, BUSY=0, DONE=0, ERR=0. RES overrides all other inputs.
- Priority at each edge: RES > LOAD > START > EN.
- LOAD, accepted in any state:
  - COUNT and RELOAD_REG ← LOAD_VAL, with each nibble >9 clamped to 9.
  - ERR ← 1 if any nibble was clamped, else 0.
  - state ← IDLE, DONE ← 0.
  - LOAD during RUN aborts the countdown; no DONE pulse.
- START in IDLE:
  - COUNT≠0: state ← RUN.
  - COUNT=0: DONE pulses next cycle; state stays IDLE.
  - START in RUN is ignored.
- RUN with EN=1: COUNT decrements by one in BCD.
  - Digit i: if digit=0 and borrow_in=1, it becomes 9 with borrow_out=1; otherwise digit ← digit − borrow_in and borrow_out=0.
  - borrow_in of digit 0 is 1.
  - Example: 10→09, 100→099.
- RUN with EN=0: COUNT holds; BUSY stays 1.
- Terminal count, on the edge where COUNT goes from 1 to 0:
  - DONE=1 for exactly one cycle.
  - AUTO_RELOAD=0: COUNT=0 and state ← IDLE, so BUSY=0 in the same cycle as DONE.
  - AUTO_RELOAD=1: COUNT ← RELOAD_REG in place of 0 and state stays RUN. If RELOAD_REG=0, COUNT=0 and state ← IDLE.
- COUNT never leaves the legal BCD range (each nibble 0..9), including after wrap and reload.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- LOAD → COUNT updated: 1 cycle.
- START → BUSY=1: 1 cycle. The first decrement happens on the edge after BUSY rises, if EN=1.
- Countdown length: with EN held high and AUTO_RELOAD=0, starting from N loaded:
  - START at edge 0, BUSY at edge 1.
  - COUNT=0 and DONE=1 after edge 1+N, so DONE is visible N+1 cycles after the START edge.
- DONE is never high for two consecutive cycles, except with AUTO_RELOAD=1 and a reload value of 1.
- Simultaneous events:
  - LOAD with terminal count on the same edge: LOAD wins; no DONE.
  - LOAD with START on the same edge: LOAD wins; state is IDLE.

## Structure
- Shared package bcd_pkg holds:
  - state enum {IDLE, RUN};
  - constant BCD_MAX = 4'd9;
  - function bcd_clamp(nibble).
- Sub-module bcd_digit_down: one 4-bit digit with borrow_in, load, load_val, and outputs digit/borrow_out. The top level instantiates it DIGITS times, borrow-chained LSD to MSD.
- The top level holds the FSM, RELOAD_REG, the zero/one detection across all digits, and the DONE/ERR registers.

## Test plan
- Reset and load, DIGITS=2: assert RES, then LOAD_VAL=8'h25 → COUNT=0, BUSY=0, DONE=0, ERR=0 after reset; COUNT=8'h25 one cycle after LOAD.
- Full countdown, DIGITS=2: load 8'h12, START, EN held high → COUNT sequence 12,11,10,09,…,00; DONE high once, 13 cycles after the START edge; BUSY falls with DONE.
- Borrow chain, DIGITS=3: load 12'h100, run one step → 12'h099. Gate EN low for 3 cycles mid-run → COUNT holds and BUSY stays 1.
- Clamp and abort: LOAD_VAL=8'hA7 → COUNT=8'h97, ERR=1. START, then LOAD 8'h05 after 3 counts → state IDLE, COUNT=8'h05, ERR=0, no DONE.
- Zero start and priority: load 0 then START → DONE pulse next cycle, BUSY stays 0. LOAD and START on the same edge → IDLE with COUNT=LOAD_VAL. RES during RUN → all outputs 0 next cycle.
- Auto-reload, AUTO_RELOAD=1: load 8'h03, START, EN high → COUNT sequence 03,02,01,03,02,…; DONE pulses every 3 cycles; BUSY stays 1.
